// File: rtl/ixc_readback_32.sv
// ixc_readback_32: snapshot a WIDTH-bit net and stream it LSB-first as SER_W-bit beats.
// Optional trailing even-parity beat when IXC_READBACK_PARITY_EN is defined.
module ixc_readback_32 #(
  parameter int WIDTH  = 32,
  parameter int SER_W  = 1,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  R,
  input  logic              snap_req,
  output logic              busy,
  output logic              so_valid,
  input  logic              so_ready,
  output logic [SER_W-1:0]  so_data,
  output logic              so_last,
  output logic              done,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int NBEATS = WIDTH / SER_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
`ifdef IXC_READBACK_PARITY_EN
    ,
    S_PAR   = 2'd2
`endif
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_shift;
  logic [CNT_W-1:0]  r_beat;
  logic [DROP_W-1:0] r_drop;
  logic              r_done;
`ifdef IXC_READBACK_PARITY_EN
  logic              r_par;
`endif

  logic w_hs;
  logic w_last_data;
  logic w_final_hs;
  logic w_accept;
  logic w_drop;

  assign w_last_data = (r_state == S_SHIFT) && (r_beat == LAST_BEAT);
  assign w_hs        = so_valid & so_ready;
  assign w_final_hs  = w_hs & so_last;
  // A new frame may start the same cycle the old one hands off its last beat.
  assign w_accept    = snap_req & ((r_state == S_IDLE) | w_final_hs);
  assign w_drop      = snap_req & ~w_accept;

  assign done     = r_done;
  assign drop_cnt = r_drop;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and beat outputs; outputs depend on state only.
  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    so_valid = 1'b0;
    so_last  = 1'b0;
    so_data  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (snap_req) begin
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy     = 1'b1;
        so_valid = 1'b1;
        so_data  = r_shift[SER_W-1:0];
`ifdef IXC_READBACK_PARITY_EN
        if (so_ready && w_last_data) begin
          w_next = S_PAR;
        end
`else
        so_last = w_last_data;
        if (so_ready && w_last_data) begin
          w_next = snap_req ? S_SHIFT : S_IDLE;
        end
`endif
      end
`ifdef IXC_READBACK_PARITY_EN
      S_PAR: begin
        busy     = 1'b1;
        so_valid = 1'b1;
        so_last  = 1'b1;
        so_data  = SER_W'(r_par);
        if (so_ready) begin
          w_next = snap_req ? S_SHIFT : S_IDLE;
        end
      end
`endif
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Snapshot capture and per-handshake shift; stalls leave the beat untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_beat  <= '0;
    end else if (w_accept) begin
      r_shift <= R;
      r_beat  <= '0;
    end else if (w_hs && (r_state == S_SHIFT)) begin
      r_shift <= r_shift >> SER_W;
      r_beat  <= r_beat + CNT_W'(1);
    end
  end

`ifdef IXC_READBACK_PARITY_EN
  // Even parity of the whole snapshot, latched with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= ^R;
    end
  end
`endif

  // Frame-complete pulse, one cycle after the last handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_final_hs;
    end
  end

  // Saturating count of rejected snapshot requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != '1)) begin
      r_drop <= r_drop + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_ixc_readback_32.sv
// tb_ixc_readback_32: two instances (SER_W=1/DROP_W=8, SER_W=8/DROP_W=2) share stimulus.
// A frame-queue model is compared every cycle; directed literals pin the model.
module tb_ixc_readback_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        snap_req;
  logic        so_ready;
  logic [31:0] R;

  logic       b0, v0, l0, d0;
  logic [0:0] sd0;
  logic [7:0] dc0;
  logic       b1, v1, l1, d1;
  logic [7:0] sd1;
  logic [1:0] dc1;

  always #5 clk = ~clk;

  ixc_readback_32 #(.WIDTH(32), .SER_W(1), .DROP_W(8)) u0 (
    .clk(clk), .rst(rst), .R(R), .snap_req(snap_req),
    .busy(b0), .so_valid(v0), .so_ready(so_ready),
    .so_data(sd0), .so_last(l0), .done(d0), .drop_cnt(dc0)
  );

  ixc_readback_32 #(.WIDTH(32), .SER_W(8), .DROP_W(2)) u1 (
    .clk(clk), .rst(rst), .R(R), .snap_req(snap_req),
    .busy(b1), .so_valid(v1), .so_ready(so_ready),
    .so_data(sd1), .so_last(l1), .done(d1), .drop_cnt(dc1)
  );

  logic        a_busy [2];
  logic        a_vld  [2];
  logic        a_last [2];
  logic        a_done [2];
  logic [31:0] a_data [2];
  logic [31:0] a_drop [2];

  assign a_busy[0] = b0;
  assign a_busy[1] = b1;
  assign a_vld[0]  = v0;
  assign a_vld[1]  = v1;
  assign a_last[0] = l0;
  assign a_last[1] = l1;
  assign a_done[0] = d0;
  assign a_done[1] = d1;
  assign a_data[0] = 32'(sd0);
  assign a_data[1] = 32'(sd1);
  assign a_drop[0] = 32'(dc0);
  assign a_drop[1] = 32'(dc1);

  int n_asrt = 0;
  int n_fail = 0;
  bit armed  = 0;

  int unsigned serw [2] = '{1, 8};
  int unsigned dmax [2] = '{255, 3};

  logic [31:0] mq    [2][$];
  int unsigned mdrop [2];
  bit          mdone [2];
  bit          m_hs, m_fin, m_acc;

  logic [31:0] logq  [2][$];
  logic        lastq [2][$];
  int          ndone [2];
  logic [31:0] exp_q [$];

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Expected beats of one frame: LSB-first slices, then optional parity.
  task automatic push_frame(input int k, input logic [31:0] r);
    int unsigned nb;
    logic [31:0] m;
    nb = 32 / serw[k];
    m  = (32'd1 << serw[k]) - 32'd1;
    for (int b = 0; b < int'(nb); b++) begin
      mq[k].push_back((r >> (b * serw[k])) & m);
    end
`ifdef IXC_READBACK_PARITY_EN
    mq[k].push_back({31'd0, ^r});
`endif
  endtask

  // Model: a frame is its queue of pending beats; accept when empty or on last pop.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mq[k].delete();
        mdrop[k] = 0;
        mdone[k] = 0;
      end else begin
        m_hs  = (mq[k].size() > 0) && so_ready;
        m_fin = m_hs && (mq[k].size() == 1);
        m_acc = snap_req && ((mq[k].size() == 0) || m_fin);
        mdone[k] = m_fin;
        if (m_hs) void'(mq[k].pop_front());
        if (m_acc) push_frame(k, R);
        else if (snap_req && (mdrop[k] < dmax[k])) mdrop[k]++;
      end
    end
  end

  // Per-cycle comparison against the model, plus handshake logging.
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        chk("busy", k, 32'(a_busy[k]), 32'(mq[k].size() > 0));
        chk("so_valid", k, 32'(a_vld[k]), 32'(mq[k].size() > 0));
        if (mq[k].size() > 0) begin
          chk("so_data", k, a_data[k], mq[k][0]);
          chk("so_last", k, 32'(a_last[k]), 32'(mq[k].size() == 1));
        end
        chk("done", k, 32'(a_done[k]), 32'(mdone[k]));
        chk("drop_cnt", k, a_drop[k], 32'(mdrop[k]));
        if (a_vld[k] && so_ready) begin
          logq[k].push_back(a_data[k]);
          lastq[k].push_back(a_last[k]);
        end
        if (a_done[k]) ndone[k]++;
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      logq[k].delete();
      lastq[k].delete();
      ndone[k] = 0;
    end
  endtask

  task automatic wait_idle(input int lim);
    int c;
    c = 0;
    while ((b0 || b1) && c < lim) begin
      cyc();
      c++;
    end
    chk("idle_timeout", 0, 32'(b0 || b1), 32'd0);
  endtask

  task automatic chk_log(input int k, input string nm);
    chk({nm, "_len"}, k, 32'(logq[k].size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk(nm, k, (i < logq[k].size()) ? logq[k][i] : 32'hxxxx_xxxx, exp_q[i]);
    end
  endtask

  task automatic pulse_snap(input logic [31:0] r);
    R = r;
    snap_req = 1'b1;
    cyc();
    snap_req = 1'b0;
  endtask

`ifdef IXC_READBACK_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  initial begin
    rst = 1'b1;
    snap_req = 1'b0;
    so_ready = 1'b0;
    R = 32'd0;
    cyc();
    armed = 1;
    cyc();
    chk("rst_busy", 0, 32'(b0), 0);
    chk("rst_valid", 0, 32'(v0), 0);
    chk("rst_data", 0, 32'(sd0), 0);
    chk("rst_last", 1, 32'(l1), 0);
    chk("rst_data", 1, 32'(sd1), 0);
    chk("rst_done", 1, 32'(d1), 0);
    chk("rst_drop", 1, 32'(dc1), 0);
    rst = 1'b0;
    cyc();

    // 1: streaming with ready held high
    clr();
    so_ready = 1'b1;
    pulse_snap(32'hA5A5_0001);
    wait_idle(80);
    chk("t1_len", 0, 32'(logq[0].size()), 32'(32 + PB));
    chk("t1_b0", 0, logq[0][0], 32'd1);
    chk("t1_b1", 0, logq[0][1], 32'd0);
    chk("t1_b2", 0, logq[0][2], 32'd0);
    chk("t1_b16", 0, logq[0][16], 32'd1);
    chk("t1_last", 0, 32'(lastq[0][31 + PB]), 32'd1);
    chk("t1_notlast", 0, 32'(lastq[0][30 + PB]), 32'd0);
    chk("t1_ndone", 0, 32'(ndone[0]), 32'd1);
    exp_q = '{32'h01, 32'h00, 32'hA5, 32'hA5};
    if (PB == 1) exp_q.push_back(32'h01);
    chk_log(1, "t1_beats");
    chk("t1_ndone", 1, 32'(ndone[1]), 32'd1);

    // 2: ready toggling every cycle
    clr();
    pulse_snap(32'h1234_5678);
    for (int i = 0; i < 200 && (b0 || b1); i++) begin
      so_ready = ~so_ready;
      cyc();
    end
    wait_idle(4);
    exp_q = '{32'h78, 32'h56, 32'h34, 32'h12};
    if (PB == 1) exp_q.push_back(32'h01);
    chk_log(1, "t2_beats");
    chk("t2_len", 0, 32'(logq[0].size()), 32'(32 + PB));

    // 3: requests while busy are dropped, DROP_W=2 saturates
    clr();
    so_ready = 1'b0;
    pulse_snap(32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      pulse_snap(32'h1111_1111);
      cyc();
    end
    chk("t3_drop3", 0, 32'(dc0), 32'd3);
    chk("t3_drop3", 1, 32'(dc1), 32'd3);
    for (int i = 0; i < 2; i++) begin
      pulse_snap(32'h2222_2222);
      cyc();
    end
    chk("t3_drop5", 0, 32'(dc0), 32'd5);
    chk("t3_sat", 1, 32'(dc1), 32'd3);
    so_ready = 1'b1;
    wait_idle(80);

    // 4: back-to-back frame on u1's final handshake
    clr();
    pulse_snap(32'hCAFE_BABE);
    for (int i = 0; i < 12 && !(v1 && l1); i++) cyc();
    chk("t4_at_last", 1, 32'(v1 && l1), 32'd1);
    pulse_snap(32'hFFFF_0000);
    chk("t4_valid", 1, 32'(v1), 32'd1);
    chk("t4_first", 1, 32'(sd1), 32'h00);
    chk("t4_done", 1, 32'(d1), 32'd1);
    wait_idle(80);
    if (PB == 1)
      exp_q = '{32'hBE, 32'hBA, 32'hFE, 32'hCA, 32'h00,
                32'h00, 32'h00, 32'hFF, 32'hFF, 32'h00};
    else
      exp_q = '{32'hBE, 32'hBA, 32'hFE, 32'hCA,
                32'h00, 32'h00, 32'hFF, 32'hFF};
    chk_log(1, "t4_beats");
    chk("t4_ndone", 1, 32'(ndone[1]), 32'd2);

    // 5: reset mid-frame, then a clean frame
    pulse_snap(32'h1357_9BDF);
    for (int i = 0; i < 10; i++) cyc();
    rst = 1'b1;
    cyc();
    chk("t5_busy", 0, 32'(b0), 0);
    chk("t5_valid", 0, 32'(v0), 0);
    chk("t5_data", 0, 32'(sd0), 0);
    chk("t5_last", 0, 32'(l0), 0);
    chk("t5_done", 0, 32'(d0), 0);
    chk("t5_drop", 0, 32'(dc0), 0);
    rst = 1'b0;
    clr();
    cyc();
    pulse_snap(32'h0F0F_3C3C);
    wait_idle(80);
    chk("t5_len", 0, 32'(logq[0].size()), 32'(32 + PB));
    chk("t5_b0", 0, logq[0][0], 32'd0);
    chk("t5_b2", 0, logq[0][2], 32'd1);
    chk("t5_ndone", 0, 32'(ndone[0]), 32'd1);
    chk("t5_u1b0", 1, logq[1][0], 32'h3C);
    chk("t5_u1b3", 1, logq[1][3], 32'h0F);

    // 6: small value; parity beat is 01 when built in
    clr();
    pulse_snap(32'h0000_0007);
    wait_idle(80);
    exp_q = '{32'h07, 32'h00, 32'h00, 32'h00};
    if (PB == 1) exp_q.push_back(32'h01);
    chk_log(1, "t6_beats");
    for (int i = 0; i < lastq[1].size(); i++) begin
      chk("t6_last", 1, 32'(lastq[1][i]), 32'(i == 3 + PB));
    end

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
